// File: rtl/parametrised_memory_subsystem.sv
// -----------------------------------------------------------------------------
// parametrised_memory_subsystem
// Byte-addressed single-port data memory for the MERC-16 datapath.
//   * valid/ready request handshake, one response pulse per access
//   * byte and word accesses, little-endian lane mapping
//   * misaligned word accesses are split into two memory cycles
//     (IDLE -> SPLIT -> IDLE), with the index of the second word wrapping
//     modulo DEPTH_WORDS
// Optional build macro: MEM_ALIGN_FAULT_EN
//   When defined, a misaligned word access is not split. It is answered one
//   cycle later with RespFault=1 and memory is left untouched. When undefined,
//   RespFault is tied to 0.
// -----------------------------------------------------------------------------
module parametrised_memory_subsystem #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  ReqWrite,
  input  logic                  ReqSize,
  input  logic [ADDR_WIDTH-1:0] ByteAddress,
  input  logic [DATA_WIDTH-1:0] DIN,
  output logic                  RespValid,
  output logic                  RespFault,
  output logic [DATA_WIDTH-1:0] DOUT
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } state_t;

  // Storage: one word per entry, written lane by lane. Not reset.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  // Registered state and outputs
  state_t                state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;

  // Context carried from the first to the second half of a split access
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [OFF_W-1:0]      off_q, off_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;

`ifdef MEM_ALIGN_FAULT_EN
  logic                  resp_fault_q, resp_fault_d;
`endif

  // Request decode and memory port signals
  logic                    accept_s;
  logic [OFF_W-1:0]        off_s;
  logic [IDX_W-1:0]        req_idx_s;
  logic [IDX_W-1:0]        mem_idx_s;
  logic [DATA_WIDTH-1:0]   mem_rd_s;
  logic                    mem_we_s;
  logic [BYTES-1:0]        mem_be_s;
  logic [DATA_WIDTH-1:0]   mem_wdata_s;
  logic [OFF_W-1:0]        sel_off_s;
  logic [DATA_WIDTH-1:0]   sel_din_s;
  logic [2*DATA_WIDTH-1:0] wide_wr_s;
  logic [2*DATA_WIDTH-1:0] wide_rd_s;
  logic [7:0]              byte_rd_s;

  assign accept_s  = ReqValid & ready_q;
  assign off_s     = OFF_W'(ByteAddress % ADDR_WIDTH'(BYTES));
  assign req_idx_s = IDX_W'(ByteAddress / ADDR_WIDTH'(BYTES));

  // Memory port address and shifted data paths; SPLIT works on the next word
  always_comb begin
    if (state_q == ST_SPLIT) begin
      mem_idx_s = idx_q + IDX_W'(1);
      sel_off_s = off_q;
      sel_din_s = din_q;
    end else begin
      mem_idx_s = req_idx_s;
      sel_off_s = off_s;
      sel_din_s = DIN;
    end
    mem_rd_s  = mem_q[mem_idx_s];
    // Low half lands in the first word (lanes >= offset), high half in the next
    wide_wr_s = {{DATA_WIDTH{1'b0}}, sel_din_s} << {sel_off_s, 3'b000};
    // Second word above the captured first word; shift drops the lanes below offset
    wide_rd_s = {mem_rd_s, lo_q} >> {off_q, 3'b000};
    byte_rd_s = 8'(mem_rd_s >> {off_s, 3'b000});
  end

  // Next-state, memory control and response computation
  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    dout_d       = '0;
    lo_d         = lo_q;
    idx_d        = idx_q;
    off_d        = off_q;
    wr_d         = wr_q;
    din_d        = din_q;
    mem_we_s     = 1'b0;
    mem_be_s     = '0;
    mem_wdata_s  = '0;
`ifdef MEM_ALIGN_FAULT_EN
    resp_fault_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (!ReqSize) begin
            // Byte access: one lane, read data zero-extended
            mem_we_s     = ReqWrite;
            mem_be_s     = BYTES'(1) << off_s;
            mem_wdata_s  = {BYTES{DIN[7:0]}};
            resp_valid_d = 1'b1;
            dout_d       = ReqWrite ? '0 : DATA_WIDTH'(byte_rd_s);
          end else if (off_s == '0) begin
            // Aligned word access
            mem_we_s     = ReqWrite;
            mem_be_s     = {BYTES{1'b1}};
            mem_wdata_s  = DIN;
            resp_valid_d = 1'b1;
            dout_d       = ReqWrite ? '0 : mem_rd_s;
          end else begin
`ifdef MEM_ALIGN_FAULT_EN
            // Misaligned word: rejected with a fault, memory untouched
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
`else
            // Misaligned word: first half now, remember context for SPLIT
            mem_we_s    = ReqWrite;
            mem_be_s    = {BYTES{1'b1}} << off_s;
            mem_wdata_s = wide_wr_s[DATA_WIDTH-1:0];
            lo_d        = mem_rd_s;
            idx_d       = req_idx_s;
            off_d       = off_s;
            wr_d        = ReqWrite;
            din_d       = DIN;
            state_d     = ST_SPLIT;
`endif
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SPLIT: begin
        // Second half: lanes below the offset of the following word
        mem_we_s     = wr_q;
        mem_be_s     = ~({BYTES{1'b1}} << off_q);
        mem_wdata_s  = wide_wr_s[2*DATA_WIDTH-1:DATA_WIDTH];
        resp_valid_d = 1'b1;
        dout_d       = wr_q ? '0 : wide_rd_s[DATA_WIDTH-1:0];
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE) ? 1'b1 : 1'b0;
  end

  // FSM, handshake, response and split-context registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      dout_q       <= '0;
      lo_q         <= '0;
      idx_q        <= '0;
      off_q        <= '0;
      wr_q         <= 1'b0;
      din_q        <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      dout_q       <= dout_d;
      lo_q         <= lo_d;
      idx_q        <= idx_d;
      off_q        <= off_d;
      wr_q         <= wr_d;
      din_q        <= din_d;
    end
  end

`ifdef MEM_ALIGN_FAULT_EN
  // Misalignment fault flag, aligned with RespValid
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      resp_fault_q <= 1'b0;
    end else begin
      resp_fault_q <= resp_fault_d;
    end
  end
  assign RespFault = resp_fault_q;
`else
  assign RespFault = 1'b0;
`endif

  // Lane-masked memory write; contents survive reset
  always_ff @(posedge Clock) begin
    for (int b = 0; b < BYTES; b++) begin
      if (mem_we_s && mem_be_s[b]) begin
        mem_q[mem_idx_s][b*8 +: 8] <= mem_wdata_s[b*8 +: 8];
      end
    end
  end

  assign ReqReady  = ready_q;
  assign RespValid = resp_valid_q;
  assign DOUT      = dout_q;

endmodule

// File: tb/tb_parametrised_memory_subsystem.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for parametrised_memory_subsystem.
// A flat byte array models the memory (byte address modulo total bytes);
// each accepted request pushes its expected response and response cycle,
// and a negedge monitor pops and compares whenever RespValid is seen.
// Build with +define+MEM_ALIGN_FAULT_EN to exercise the fault variant.
// -----------------------------------------------------------------------------
module tb_parametrised_memory_subsystem;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 1024;
  localparam int BYTES = DW / 8;
  localparam int TOTAL = DEPTH * BYTES;

  logic          Clock;
  logic          Reset;
  logic          ReqValid;
  logic          ReqReady;
  logic          ReqWrite;
  logic          ReqSize;
  logic [AW-1:0] ByteAddress;
  logic [DW-1:0] DIN;
  logic          RespValid;
  logic          RespFault;
  logic [DW-1:0] DOUT;

  parametrised_memory_subsystem #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH_WORDS(DEPTH)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .ReqValid   (ReqValid),
    .ReqReady   (ReqReady),
    .ReqWrite   (ReqWrite),
    .ReqSize    (ReqSize),
    .ByteAddress(ByteAddress),
    .DIN        (DIN),
    .RespValid  (RespValid),
    .RespFault  (RespFault),
    .DOUT       (DOUT)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          fault;
    int            cyc;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] mm [TOTAL];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  // Reference model: word at a is bytes a, a+1, ... (little-endian, wrapping)
  function automatic logic [DW-1:0] m_read(input int unsigned a, input logic sz);
    logic [DW-1:0] r;
    r = '0;
    if (sz) begin
      for (int k = 0; k < BYTES; k++) r[k*8 +: 8] = mm[(a + k) % TOTAL];
    end else begin
      r[7:0] = mm[a % TOTAL];
    end
    return r;
  endfunction

  function automatic void m_write(input int unsigned a, input logic [DW-1:0] d, input int n);
    for (int k = 0; k < n; k++) mm[(a + k) % TOTAL] = d[k*8 +: 8];
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, expv);
    end
  endtask

  // Issue one request; records expectation at the accepting edge
  task automatic do_op(input logic wr, input logic sz, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    int   w;
    logic mis;
    logic flt;
    int   lat;
    exp_t e;
    w = 0;
    @(negedge Clock);
    ReqValid    = 1'b1;
    ReqWrite    = wr;
    ReqSize     = sz;
    ByteAddress = a;
    DIN         = d;
    while (!ReqReady && w < 8) begin
      @(negedge Clock);
      w++;
    end
    if (!ReqReady) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout addr=%h ReqReady=%b expected 1", a, ReqReady);
      ReqValid = 1'b0;
      return;
    end
    mis = sz && ((a % BYTES) != 0);
`ifdef MEM_ALIGN_FAULT_EN
    flt = mis;
    lat = 1;
`else
    flt = 1'b0;
    lat = mis ? 2 : 1;
`endif
    e.fault = flt;
    e.cyc   = cyc + lat;
    if (wr) begin
      e.data = '0;
      if (!flt) m_write(a, d, sz ? BYTES : 1);
    end else begin
      e.data = flt ? '0 : m_read(a, sz);
    end
    sb.push_back(e);
    @(posedge Clock);
    #1;
    chk("ready_after_accept", {{(DW-1){1'b0}}, ReqReady}, (lat == 1) ? 16'd1 : 16'd0);
  endtask

  // Monitor: compare every response against the oldest expectation
  always @(negedge Clock) begin
    exp_t m;
    if (Reset) begin
      if (RespValid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp DOUT=%h fault=%b at cycle %0d", DOUT, RespFault, cyc);
        end else begin
          m = sb.pop_front();
          if (DOUT !== m.data || RespFault !== m.fault || cyc != m.cyc) begin
            errors++;
            $display("FAIL resp got data=%h fault=%b cyc=%0d expected data=%h fault=%b cyc=%0d",
                     DOUT, RespFault, cyc, m.data, m.fault, m.cyc);
          end
        end
      end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_resp expected data=%h at cycle %0d, now %0d",
                 sb[0].data, sb[0].cyc, cyc);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic [DW-1:0] d;
    Reset       = 1'b0;
    ReqValid    = 1'b0;
    ReqWrite    = 1'b0;
    ReqSize     = 1'b0;
    ByteAddress = '0;
    DIN         = '0;
    #2;
    chk("reset_respvalid", {{(DW-1){1'b0}}, RespValid}, 16'd0);
    chk("reset_respfault", {{(DW-1){1'b0}}, RespFault}, 16'd0);
    chk("reset_dout", DOUT, 16'd0);
    chk("reset_ready", {{(DW-1){1'b0}}, ReqReady}, 16'd0);
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    #1;
    chk("ready_before_edge", {{(DW-1){1'b0}}, ReqReady}, 16'd0);
    @(negedge Clock);
    chk("ready_after_edge", {{(DW-1){1'b0}}, ReqReady}, 16'd1);

    // Fill memory with known contents
    for (int i = 0; i < DEPTH; i++) do_op(1'b1, 1'b1, AW'(i * BYTES), DW'($urandom));

    // Directed sequences from the plan
    do_op(1'b1, 1'b1, 16'h0004, 16'hBEEF);
    do_op(1'b0, 1'b1, 16'h0004, 16'h0000);
    do_op(1'b1, 1'b0, 16'h0005, 16'h00AA);
    do_op(1'b0, 1'b1, 16'h0004, 16'h0000);
    do_op(1'b0, 1'b0, 16'h0004, 16'h0000);
    do_op(1'b0, 1'b0, 16'h0005, 16'h0000);
    do_op(1'b1, 1'b1, 16'h0007, 16'h1234);
    do_op(1'b0, 1'b0, 16'h0007, 16'h0000);
    do_op(1'b0, 1'b0, 16'h0008, 16'h0000);
    do_op(1'b0, 1'b1, 16'h0007, 16'h0000);
    do_op(1'b1, 1'b1, 16'h07FF, 16'h5678);
    do_op(1'b0, 1'b0, 16'h07FF, 16'h0000);
    do_op(1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int i = 0; i < 10; i++) do_op(1'b0, 1'b1, AW'(i * 2), 16'h0000);
    @(negedge Clock);
    ReqValid = 1'b0;
    repeat (4) @(negedge Clock);

`ifndef MEM_ALIGN_FAULT_EN
    // Reset during SPLIT of a misaligned write: first half only, no response
    d = DW'($urandom);
    @(negedge Clock);
    ReqValid    = 1'b1;
    ReqWrite    = 1'b1;
    ReqSize     = 1'b1;
    ByteAddress = 16'h0101;
    DIN         = d;
    chk("ready_before_split", {{(DW-1){1'b0}}, ReqReady}, 16'd1);
    m_write(32'h0101, d, BYTES - 1);
    @(posedge Clock);
    #1;
    chk("ready_in_split", {{(DW-1){1'b0}}, ReqReady}, 16'd0);
    @(negedge Clock);
    ReqValid = 1'b0;
    Reset    = 1'b0;
    #1;
    chk("abort_respvalid", {{(DW-1){1'b0}}, RespValid}, 16'd0);
    chk("abort_ready", {{(DW-1){1'b0}}, ReqReady}, 16'd0);
    chk("abort_dout", DOUT, 16'd0);
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    #1;
    chk("rel_ready_before_edge", {{(DW-1){1'b0}}, ReqReady}, 16'd0);
    @(negedge Clock);
    chk("rel_ready_after_edge", {{(DW-1){1'b0}}, ReqReady}, 16'd1);
    do_op(1'b0, 1'b1, 16'h0100, 16'h0000);
    do_op(1'b0, 1'b1, 16'h0102, 16'h0000);
    do_op(1'b0, 1'b1, 16'h0101, 16'h0000);
`else
    // Misaligned write faults and leaves memory unchanged
    do_op(1'b1, 1'b1, 16'h0003, 16'hDEAD);
    do_op(1'b0, 1'b1, 16'h0002, 16'h0000);
    do_op(1'b0, 1'b1, 16'h0004, 16'h0000);
    do_op(1'b0, 1'b1, 16'h0003, 16'h0000);
`endif

    // Randomised traffic: mixed sizes, alignments, aliasing and idles
    for (int i = 0; i < 500; i++) begin
      logic [AW-1:0] a;
      if ($urandom_range(0, 7) == 0) begin
        @(negedge Clock);
        ReqValid = 1'b0;
      end
      a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 31));
      do_op(1'($urandom), 1'($urandom), a, DW'($urandom));
    end

    @(negedge Clock);
    ReqValid = 1'b0;
    repeat (5) @(negedge Clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending_at_end got %0d outstanding expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
